collision_checker: RTL and testbench

COLLISION_CHECKER -- requirements
Module: collision_checker

---
 rtl/collision_checker_pkg.sv | 47 ++++
 rtl/collision_checker_box_overlap.sv | 48 ++++
 rtl/define.v | 22 ++
 rtl/collision_checker.sv | 107 ++++++++++
 tb/tb_collision_checker.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/collision_checker_pkg.sv
// Shared types for the collision checker: record field positions, box struct,
// scan FSM states and the record-to-box unpack helper.
`include "define.v"

package collision_checker_pkg;

    localparam int DATALEN = `DATALEN;
    localparam int TYPE_LSB = `TYPESTART;
    localparam int TYPEW = `TYPELEN;
    localparam int X_LSB = `XSTART;
    localparam int XW = `XLEN;
    localparam int Y_LSB = `YSTART;
    localparam int YW = `YLEN;
    localparam int W_LSB = `WIDTHSTART;
    localparam int WW = `WIDTHLEN;
    localparam int H_LSB = `HEIGHTSTART;
    localparam int HW = `HEIGHTLEN;

    localparam logic [TYPEW-1:0] EMPTY_TYPE = `EMPTYTYPE;
    localparam logic [TYPEW-1:0] PLAYER_TYPE = `PLAYERTYPE;
    localparam int MARGIN = `collisionMargin;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [WW-1:0] w;
        logic [HW-1:0] h;
    } box_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCH   = 3'd1,
        S_SCAN    = 3'd2,
        S_RESOLVE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    function automatic box_t unpack_box(input logic [DATALEN-1:0] rec);
        box_t b;
        b.x = rec[X_LSB +: XW];
        b.y = rec[Y_LSB +: YW];
        b.w = rec[W_LSB +: WW];
        b.h = rec[H_LSB +: HW];
        return b;
    endfunction

endpackage

// File: rtl/collision_checker_box_overlap.sv
// Combinational axis-aligned overlap test of box a (player) against box b
// (obstacle). With COLLISION_MARGIN_EN defined, b is shrunk by MARGIN per side.
module box_overlap
    import collision_checker_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic overlap
);

    localparam int XS = XW + 1;
    localparam int YS = YW + 1;

    logic [XS-1:0] bx;
    logic [YS-1:0] by;
    logic [WW-1:0] bw;
    logic [HW-1:0] bh;
    logic          b_ok;

`ifdef COLLISION_MARGIN_EN
    // Anything no larger than twice the margin would shrink to nothing or
    // underflow, so it is rejected outright.
    always_comb begin
        b_ok = (b.w > WW'(2 * MARGIN)) && (b.h > HW'(2 * MARGIN));
        bx   = XS'(b.x) + XS'(MARGIN);
        by   = YS'(b.y) + YS'(MARGIN);
        bw   = b.w - WW'(2 * MARGIN);
        bh   = b.h - HW'(2 * MARGIN);
    end
`else
    always_comb begin
        b_ok = (b.w != '0) && (b.h != '0);
        bx   = XS'(b.x);
        by   = YS'(b.y);
        bw   = b.w;
        bh   = b.h;
    end
`endif

    always_comb begin
        overlap = b_ok
            && (XS'(a.x) < bx + XS'(bw))
            && (bx < XS'(a.x) + XS'(a.w))
            && (YS'(a.y) < by + YS'(bh))
            && (by < YS'(a.y) + YS'(a.h));
    end

endmodule

// File: rtl/define.v
// Shared record layout for game-object records and the collision constants.
// Record: {type, x, y, width, height}, type in the most significant bits.
`ifndef COLLISION_DEFINE_V
`define COLLISION_DEFINE_V

`define DATALEN         40
`define TYPESTART       36
`define TYPELEN         4
`define XSTART          26
`define XLEN            10
`define YSTART          16
`define YLEN            10
`define WIDTHSTART      8
`define WIDTHLEN        8
`define HEIGHTSTART     0
`define HEIGHTLEN       8

`define EMPTYTYPE       4'h0
`define PLAYERTYPE      4'h1
`define collisionMargin 2

`endif

// File: rtl/collision_checker.sv
// Per-frame obstacle scan against a latched player box; flags the first hit
// and latches a sticky gameover. Optional margin: define COLLISION_MARGIN_EN.
module collision_checker
    import collision_checker_pkg::*;
#(
    parameter int MAXOBJ = 8,
    localparam int IDXW = (MAXOBJ > 1) ? $clog2(MAXOBJ) : 1
) (
    input  logic               clk3,
    input  logic               reset,
    input  logic               pause,
    input  logic               frame,
    input  logic [DATALEN-1:0] player,
    input  logic [DATALEN-1:0] obj_data,
    input  logic               obj_valid,
    input  logic               obj_last,
    output logic               obj_ready,
    output logic               hit,
    output logic [IDXW-1:0]    hit_index,
    output logic               scan_done,
    output logic               gameover,
    output state_t             dbg_state
);

    // Handshake: a record transfers on a clk3 edge where obj_valid && obj_ready;
    // obj_ready depends only on state and pause, never on obj_valid.
    state_t          state, state_nx;
    logic [IDXW-1:0] index;
    box_t            snap;
    logic            found;
    logic            gameover_r;
    logic            xfer;
    logic            scan_end;
    logic            overlap;
    logic            obj_hit;
    logic [TYPEW-1:0] obj_type;
    logic            unused_player_type;

    assign unused_player_type = ^player[TYPE_LSB +: TYPEW];

    assign obj_ready = (state == S_SCAN) && !pause;
    assign xfer      = obj_valid && obj_ready;
    assign scan_end  = xfer && (obj_last || (index == IDXW'(MAXOBJ - 1)));
    assign obj_type  = obj_data[TYPE_LSB +: TYPEW];

    box_overlap u_box_overlap (
        .a       (snap),
        .b       (unpack_box(obj_data)),
        .overlap (overlap)
    );

    assign obj_hit   = overlap && (obj_type != EMPTY_TYPE) && (obj_type != PLAYER_TYPE);
    assign scan_done = (state == S_RESOLVE) && !pause;
    assign hit       = scan_done && found;
    assign gameover  = gameover_r || hit;
    assign dbg_state = state;

    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!pause) begin
            case (state)
                S_IDLE:    if (frame) state_nx = S_LATCH;
                S_LATCH:   state_nx = S_SCAN;
                S_SCAN:    if (scan_end) state_nx = S_RESOLVE;
                S_RESOLVE: state_nx = found ? S_HALT : S_IDLE;
                S_HALT:    state_nx = S_HALT;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            index      <= '0;
            snap       <= '0;
            found      <= 1'b0;
            hit_index  <= '0;
            gameover_r <= 1'b0;
        end else if (!pause) begin
            if (state == S_LATCH) begin
                snap      <= unpack_box(player);
                index     <= '0;
                found     <= 1'b0;
                hit_index <= '0;
            end
            if (xfer) begin
                index <= index + 1'b1;
                if (obj_hit && !found) begin
                    found     <= 1'b1;
                    hit_index <= index;
                end
            end
            if (state == S_RESOLVE && found) begin
                gameover_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// Directed bench for collision_checker: single-record vector table plus
// multi-cycle sequences (first-hit index, pause, reset mid-scan, MAXOBJ, halt).
module tb_collision_checker;
    import collision_checker_pkg::*;

    localparam int MAXOBJ = 8;
    localparam int IDXW = 3;
`ifdef COLLISION_MARGIN_EN
    localparam bit MARGIN_ON = 1'b1;
`else
    localparam bit MARGIN_ON = 1'b0;
`endif

    logic               clk3 = 1'b0;
    logic               reset;
    logic               pause;
    logic               frame;
    logic [DATALEN-1:0] player;
    logic [DATALEN-1:0] obj_data;
    logic               obj_valid;
    logic               obj_last;
    logic               obj_ready;
    logic               hit;
    logic [IDXW-1:0]    hit_index;
    logic               scan_done;
    logic               gameover;
    state_t             dbg_state;

    int errors = 0;
    int checks = 0;

    collision_checker #(.MAXOBJ(MAXOBJ)) dut (
        .clk3      (clk3),
        .reset     (reset),
        .pause     (pause),
        .frame     (frame),
        .player    (player),
        .obj_data  (obj_data),
        .obj_valid (obj_valid),
        .obj_last  (obj_last),
        .obj_ready (obj_ready),
        .hit       (hit),
        .hit_index (hit_index),
        .scan_done (scan_done),
        .gameover  (gameover),
        .dbg_state (dbg_state)
    );

    always #5 clk3 = ~clk3;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic [3:0] t;
        int         x, y, w, h;
        logic       exp_hit;
    } vec_t;

    function automatic logic [DATALEN-1:0] mk_rec(input logic [3:0] t, input int x, input int y,
                                                  input int w, input int h);
        logic [DATALEN-1:0] r;
        r = '0;
        r[TYPE_LSB +: TYPEW] = TYPEW'(t);
        r[X_LSB +: XW] = XW'(x);
        r[Y_LSB +: YW] = YW'(y);
        r[W_LSB +: WW] = WW'(w);
        r[H_LSB +: HW] = HW'(h);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk3);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pause = 1'b0;
        frame = 1'b0;
        obj_valid = 1'b0;
        obj_last = 1'b0;
        obj_data = '0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic start_frame(input logic [DATALEN-1:0] p);
        player = p;
        frame = 1'b1;
        step();
        frame = 1'b0;
        step();
    endtask

    task automatic send(input logic [DATALEN-1:0] rec, input logic last);
        int n;
        obj_valid = 1'b1;
        obj_data = rec;
        obj_last = last;
        n = 0;
        while (!obj_ready && n < 20) begin
            step();
            n++;
        end
        check("send_ready", 32'(obj_ready), 32'd1);
        step();
        obj_valid = 1'b0;
        obj_last = 1'b0;
    endtask

    logic [DATALEN-1:0] p_rec, junk_player, miss_rec, hit_a, hit_b;
    vec_t vecs[12];

    initial begin
        int accepted;
        bit seen;

        p_rec       = mk_rec(4'h1, 20, 100, 10, 10);
        junk_player = mk_rec(4'h1, 500, 500, 1, 1);
        miss_rec    = mk_rec(4'h2, 100, 105, 5, 5);
        hit_a       = mk_rec(4'h2, 25, 105, 5, 5);
        hit_b       = mk_rec(4'h3, 20, 100, 10, 10);

        vecs[0]  = '{"inside",       4'h2, 25, 105, 5, 5, 1'b1};
        vecs[1]  = '{"touch_right",  4'h2, 30, 105, 5, 5, 1'b0};
        vecs[2]  = '{"touch_left",   4'h2, 15, 105, 5, 5, 1'b0};
        vecs[3]  = '{"one_px_x",     4'h2, 16, 105, 5, 5, !MARGIN_ON};
        vecs[4]  = '{"empty_type",   4'h0, 25, 105, 5, 5, 1'b0};
        vecs[5]  = '{"player_type",  4'h1, 25, 105, 5, 5, 1'b0};
        vecs[6]  = '{"zero_width",   4'h2, 25, 105, 0, 5, 1'b0};
        vecs[7]  = '{"zero_height",  4'h2, 25, 105, 5, 0, 1'b0};
        vecs[8]  = '{"covering",     4'h5, 0, 0, 255, 255, 1'b1};
        vecs[9]  = '{"touch_bottom", 4'h2, 25, 110, 5, 5, 1'b0};
        vecs[10] = '{"one_px_y",     4'h2, 25, 96, 5, 5, !MARGIN_ON};
        vecs[11] = '{"far_right",    4'h2, 1000, 105, 100, 5, 1'b0};

        // Reset state, checked asynchronously before any clock edge.
        player = p_rec;
        reset = 1'b1;
        pause = 1'b0;
        frame = 1'b0;
        obj_valid = 1'b0;
        obj_last = 1'b0;
        obj_data = '0;
        #1;
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_ready", 32'(obj_ready), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_gameover", 32'(gameover), 32'd0);
        check("rst_hit_index", 32'(hit_index), 32'd0);
        step();
        reset = 1'b0;
        obj_valid = 1'b1;
        step();
        step();
        step();
        check("no_autostart_state", 32'(dbg_state), 32'(S_IDLE));
        check("no_autostart_ready", 32'(obj_ready), 32'd0);
        obj_valid = 1'b0;

        // Single-record scans; player input is scrambled during SCAN.
        foreach (vecs[i]) begin
            do_reset();
            start_frame(p_rec);
            player = junk_player;
            send(mk_rec(vecs[i].t, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h), 1'b1);
            check({vecs[i].name, "_done"}, 32'(scan_done), 32'd1);
            check({vecs[i].name, "_hit"}, 32'(hit), 32'(vecs[i].exp_hit));
            check({vecs[i].name, "_gameover"}, 32'(gameover), 32'(vecs[i].exp_hit));
            check({vecs[i].name, "_index"}, 32'(hit_index), 32'd0);
            step();
            check({vecs[i].name, "_done_pulse"}, 32'(scan_done), 32'd0);
            check({vecs[i].name, "_next_state"}, 32'(dbg_state),
                  vecs[i].exp_hit ? 32'(S_HALT) : 32'(S_IDLE));
            check({vecs[i].name, "_gameover_hold"}, 32'(gameover), 32'(vecs[i].exp_hit));
        end

        // First overlap wins: records 1 and 2 overlap, index 1 is reported.
        do_reset();
        start_frame(p_rec);
        send(miss_rec, 1'b0);
        send(hit_a, 1'b0);
        send(hit_b, 1'b1);
        check("first_hit_done", 32'(scan_done), 32'd1);
        check("first_hit_hit", 32'(hit), 32'd1);
        check("first_hit_index", 32'(hit_index), 32'd1);

        // HALT absorbs frame pulses and never pulses again.
        step();
        frame = 1'b1;
        step();
        frame = 1'b0;
        obj_valid = 1'b1;
        step();
        check("halt_state", 32'(dbg_state), 32'(S_HALT));
        check("halt_ready", 32'(obj_ready), 32'd0);
        check("halt_done", 32'(scan_done), 32'd0);
        check("halt_gameover", 32'(gameover), 32'd1);
        obj_valid = 1'b0;

        // Pause mid-scan with obj_valid high; frame during SCAN is ignored.
        do_reset();
        start_frame(p_rec);
        send(miss_rec, 1'b0);
        frame = 1'b1;
        step();
        frame = 1'b0;
        check("frame_in_scan", 32'(dbg_state), 32'(S_SCAN));
        pause = 1'b1;
        obj_valid = 1'b1;
        obj_data = hit_a;
        obj_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("pause_ready", 32'(obj_ready), 32'd0);
            step();
        end
        check("pause_state", 32'(dbg_state), 32'(S_SCAN));
        check("pause_no_done", 32'(scan_done), 32'd0);
        pause = 1'b0;
        #1;
        check("resume_ready", 32'(obj_ready), 32'd1);
        step();
        obj_valid = 1'b0;
        obj_last = 1'b0;
        check("resume_done", 32'(scan_done), 32'd1);
        check("resume_hit", 32'(hit), 32'd1);
        check("resume_index", 32'(hit_index), 32'd1);

        // Reset after 2 of 4 transfers, then a fresh scan starts at index 0.
        do_reset();
        start_frame(p_rec);
        send(miss_rec, 1'b0);
        send(miss_rec, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        check("midrst_ready", 32'(obj_ready), 32'd0);
        check("midrst_done", 32'(scan_done), 32'd0);
        check("midrst_hit", 32'(hit), 32'd0);
        check("midrst_gameover", 32'(gameover), 32'd0);
        step();
        reset = 1'b0;
        step();
        start_frame(p_rec);
        send(miss_rec, 1'b0);
        send(miss_rec, 1'b0);
        send(hit_a, 1'b1);
        check("rescan_hit", 32'(hit), 32'd1);
        check("rescan_index", 32'(hit_index), 32'd2);

        // Ten records offered without obj_last: scan closes after MAXOBJ.
        do_reset();
        start_frame(p_rec);
        obj_valid = 1'b1;
        obj_data = miss_rec;
        obj_last = 1'b0;
        accepted = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (obj_valid && obj_ready) accepted++;
            step();
            if (scan_done) seen = 1'b1;
        end
        check("maxobj_done", 32'(seen), 32'd1);
        check("maxobj_count", 32'(accepted), 32'(MAXOBJ));
        check("maxobj_hit", 32'(hit), 32'd0);
        step();
        check("maxobj_idle", 32'(dbg_state), 32'(S_IDLE));
        check("maxobj_ready_low", 32'(obj_ready), 32'd0);
        obj_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
